// File: rtl/uart_sched_pkg.sv
// -----------------------------------------------------------------------------
// uart_sched_pkg
// Shared definitions for the UART frame scheduler:
//   - sched_state_e    : frame sequencing states
//   - TAG_BASE_DEFAULT : default header tag base (low 3 bits must be zero)
//   - ch_width()       : width of a channel index for a given channel count
//   - make_tag()       : header byte for a channel
// -----------------------------------------------------------------------------
package uart_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_HDR_SEND = 3'd1,
      ST_HDR_WHI  = 3'd2,
      ST_HDR_WLO  = 3'd3,
      ST_DAT_SEND = 3'd4,
      ST_DAT_WHI  = 3'd5,
      ST_DAT_WLO  = 3'd6
   } sched_state_e;

   localparam logic [7:0] TAG_BASE_DEFAULT = 8'hA0;

   // Channel index width; never below one bit so ports stay legal.
   function automatic int ch_width(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

   // Header byte: only the low three bits carry the channel number.
   function automatic logic [7:0] make_tag(input logic [7:0] base, input logic [2:0] ch);
      return base | {5'b00000, ch};
   endfunction

endpackage

// File: rtl/uart_sched_rr.sv
// -----------------------------------------------------------------------------
// uart_sched_rr
// Channel picker for the UART frame scheduler. Channel 0 has strict
// priority; channels 1..NUM_CH-1 are served round-robin starting at the
// registered pointer, which moves to the channel after the last granted
// non-zero channel (wrapping back to 1).
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   pend_i       : per-channel pending flags
//   adv_i        : a grant is being taken this cycle (advances the pointer)
//   any_o        : at least one channel pending
//   grant_ch_o   : selected channel (combinational)
// -----------------------------------------------------------------------------
module uart_sched_rr
   import uart_sched_pkg::*;
#(
   parameter int NUM_CH = 3
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic [NUM_CH-1:0]             pend_i,
   input  logic                          adv_i,
   output logic                          any_o,
   output logic [ch_width(NUM_CH)-1:0]   grant_ch_o
);

   localparam int CH_W = ch_width(NUM_CH);

   logic [CH_W-1:0] ptr_q;
   logic [CH_W-1:0] ptr_d;
   logic [CH_W-1:0] hi_ch_s;
   logic            hi_vld_s;
   logic [CH_W-1:0] lo_ch_s;
   logic            lo_vld_s;

   // Two descending scans so the lowest qualifying channel wins: "hi" only
   // looks at channels at or above the pointer, "lo" is the wrap-around.
   always_comb begin
      hi_ch_s  = {CH_W{1'b0}};
      hi_vld_s = 1'b0;
      lo_ch_s  = {CH_W{1'b0}};
      lo_vld_s = 1'b0;
      for (int c = NUM_CH - 1; c >= 1; c--) begin
         hi_ch_s  = (pend_i[c] && (CH_W'(c) >= ptr_q)) ? CH_W'(c) : hi_ch_s;
         hi_vld_s = (pend_i[c] && (CH_W'(c) >= ptr_q)) ? 1'b1     : hi_vld_s;
         lo_ch_s  = pend_i[c] ? CH_W'(c) : lo_ch_s;
         lo_vld_s = pend_i[c] ? 1'b1     : lo_vld_s;
      end
   end

   // Final selection: channel 0 first, then round-robin order.
   always_comb begin
      any_o = |pend_i;
      if (pend_i[0]) begin
         grant_ch_o = {CH_W{1'b0}};
      end else if (hi_vld_s) begin
         grant_ch_o = hi_ch_s;
      end else if (lo_vld_s) begin
         grant_ch_o = lo_ch_s;
      end else begin
         grant_ch_o = {CH_W{1'b0}};
      end
   end

   // Next pointer: one past the granted non-zero channel, wrapping to 1.
   always_comb begin
      if (adv_i && (grant_ch_o != {CH_W{1'b0}})) begin
         if (grant_ch_o == CH_W'(NUM_CH - 1)) begin
            ptr_d = CH_W'(1);
         end else begin
            ptr_d = grant_ch_o + CH_W'(1);
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         ptr_q <= CH_W'(1);
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one uart_send transmitter between NUM_CH byte producers. Each
// producer strobes a byte in; the byte is held as pending, channels are
// arbitrated in IDLE, and a frame (tag byte TAG_BASE|ch, then payload, or
// payload only when HDR_EN=0) is pushed through the uart_en / uart_din /
// uart_tx_busy handshake.
// Ports:
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   req_valid        : per-channel one-cycle request strobe
//   req_data         : per-channel payload, channel c in [8c+7:8c]
//   uart_en          : one-cycle send pulse to the transmitter
//   uart_din         : byte being sent, held until the next send
//   uart_tx_busy     : transmitter busy
//   grant_ch         : channel of the frame in progress (valid when idle=0)
//   sent             : one-cycle pulse per channel on frame completion
//   overflow         : one-cycle pulse when a pending byte is overwritten
//   tx_error         : one-cycle pulse when busy never rose after a send
//   idle             : high while waiting for work
// -----------------------------------------------------------------------------
module uart_tx_scheduler
   import uart_sched_pkg::*;
#(
   parameter int          NUM_CH       = 3,
   parameter logic [7:0]  TAG_BASE     = TAG_BASE_DEFAULT,
   parameter int          HDR_EN       = 1,
   parameter int          BUSY_TIMEOUT = 64
) (
   input  logic                          sys_clk,
   input  logic                          sys_rst,
   input  logic [NUM_CH-1:0]             req_valid,
   input  logic [8*NUM_CH-1:0]           req_data,
   output logic                          uart_en,
   output logic [7:0]                    uart_din,
   input  logic                          uart_tx_busy,
   output logic [ch_width(NUM_CH)-1:0]   grant_ch,
   output logic [NUM_CH-1:0]             sent,
   output logic [NUM_CH-1:0]             overflow,
   output logic                          tx_error,
   output logic                          idle
);

   localparam int CH_W  = ch_width(NUM_CH);
   localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

   sched_state_e      state_q;
   logic [NUM_CH-1:0] pend_q;
   logic [NUM_CH-1:0] pend_d;
   logic [7:0]        pbuf_q [NUM_CH];
   logic [7:0]        sbuf_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_d;
   logic              uart_en_q;
   logic [7:0]        uart_din_q;
   logic [CH_W-1:0]   grant_q;
   logic [NUM_CH-1:0] sent_q;
   logic [NUM_CH-1:0] overflow_q;
   logic [NUM_CH-1:0] overflow_d;
   logic              tx_error_q;
   logic              idle_q;

   logic              rr_any_s;
   logic [CH_W-1:0]   rr_grant_s;
   logic              grant_now_s;
   logic [7:0]        pbuf_sel_s;
   logic [7:0]        tag_s;
   logic [NUM_CH-1:0] sent_onehot_s;
   logic              timeout_s;

   uart_sched_rr #(
      .NUM_CH (NUM_CH)
   ) u_rr (
      .clk_i      (sys_clk),
      .rst_i      (sys_rst),
      .pend_i     (pend_q),
      .adv_i      (grant_now_s),
      .any_o      (rr_any_s),
      .grant_ch_o (rr_grant_s)
   );

   // A grant is only taken from IDLE with the transmitter free, which also
   // keeps uart_en off while busy is high.
   assign grant_now_s = (state_q == ST_IDLE) && rr_any_s && !uart_tx_busy;

   // Timeout counter increment and terminal condition.
   assign cnt_d     = cnt_q + CNT_W'(1);
   assign timeout_s = (cnt_d == CNT_W'(BUSY_TIMEOUT));

   // Payload of the granted channel, header tag and completion one-hot.
   always_comb begin
      pbuf_sel_s    = 8'h00;
      sent_onehot_s = {NUM_CH{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
         pbuf_sel_s       = (rr_grant_s == CH_W'(c)) ? pbuf_q[c] : pbuf_sel_s;
         sent_onehot_s[c] = (grant_q == CH_W'(c));
      end
      tag_s = make_tag(TAG_BASE, 3'(rr_grant_s));
   end

   // Pending flags: a new strobe always sets (and beats a same-cycle grant
   // clear); overwriting a still-pending byte flags an overflow unless that
   // byte is being taken by the grant in the same cycle.
   always_comb begin
      pend_d     = pend_q;
      overflow_d = {NUM_CH{1'b0}};
      for (int c = 0; c < NUM_CH; c++) begin
         if (req_valid[c]) begin
            pend_d[c]     = 1'b1;
            overflow_d[c] = pend_q[c] && !(grant_now_s && (rr_grant_s == CH_W'(c)));
         end else if (grant_now_s && (rr_grant_s == CH_W'(c))) begin
            pend_d[c]     = 1'b0;
            overflow_d[c] = 1'b0;
         end else begin
            pend_d[c]     = pend_q[c];
            overflow_d[c] = 1'b0;
         end
      end
   end

   // Pending flags, payload buffers and overflow pulse.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pend_q     <= {NUM_CH{1'b0}};
         overflow_q <= {NUM_CH{1'b0}};
         for (int c = 0; c < NUM_CH; c++) begin
            pbuf_q[c] <= 8'h00;
         end
      end else begin
         pend_q     <= pend_d;
         overflow_q <= overflow_d;
         for (int c = 0; c < NUM_CH; c++) begin
            if (req_valid[c]) begin
               pbuf_q[c] <= req_data[8*c +: 8];
            end else begin
               pbuf_q[c] <= pbuf_q[c];
            end
         end
      end
   end

   // Frame sequencer with registered handshake and status outputs.
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q    <= ST_IDLE;
         uart_en_q  <= 1'b0;
         uart_din_q <= 8'h00;
         grant_q    <= {CH_W{1'b0}};
         sent_q     <= {NUM_CH{1'b0}};
         tx_error_q <= 1'b0;
         idle_q     <= 1'b1;
         sbuf_q     <= 8'h00;
         cnt_q      <= {CNT_W{1'b0}};
      end else begin
         uart_en_q  <= 1'b0;
         sent_q     <= {NUM_CH{1'b0}};
         tx_error_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant_now_s) begin
                  grant_q   <= rr_grant_s;
                  sbuf_q    <= pbuf_sel_s;
                  idle_q    <= 1'b0;
                  uart_en_q <= 1'b1;
                  cnt_q     <= {CNT_W{1'b0}};
                  if (HDR_EN != 0) begin
                     state_q    <= ST_HDR_SEND;
                     uart_din_q <= tag_s;
                  end else begin
                     state_q    <= ST_DAT_SEND;
                     uart_din_q <= pbuf_sel_s;
                  end
               end else begin
                  idle_q <= 1'b1;
               end
            end
            ST_HDR_SEND: begin
               state_q <= ST_HDR_WHI;
            end
            ST_HDR_WHI: begin
               if (uart_tx_busy) begin
                  state_q <= ST_HDR_WLO;
               end else if (timeout_s) begin
                  // Frame is dropped; pending state is not restored.
                  state_q    <= ST_IDLE;
                  tx_error_q <= 1'b1;
                  idle_q     <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_HDR_WLO: begin
               if (!uart_tx_busy) begin
                  state_q    <= ST_DAT_SEND;
                  uart_en_q  <= 1'b1;
                  uart_din_q <= sbuf_q;
                  cnt_q      <= {CNT_W{1'b0}};
               end else begin
                  state_q <= ST_HDR_WLO;
               end
            end
            ST_DAT_SEND: begin
               state_q <= ST_DAT_WHI;
            end
            ST_DAT_WHI: begin
               if (uart_tx_busy) begin
                  state_q <= ST_DAT_WLO;
               end else if (timeout_s) begin
                  state_q    <= ST_IDLE;
                  tx_error_q <= 1'b1;
                  idle_q     <= 1'b1;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            ST_DAT_WLO: begin
               if (!uart_tx_busy) begin
                  state_q <= ST_IDLE;
                  sent_q  <= sent_onehot_s;
                  idle_q  <= 1'b1;
               end else begin
                  state_q <= ST_DAT_WLO;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               idle_q  <= 1'b1;
            end
         endcase
      end
   end

   assign uart_en  = uart_en_q;
   assign uart_din = uart_din_q;
   assign grant_ch = grant_q;
   assign sent     = sent_q;
   assign overflow = overflow_q;
   assign tx_error = tx_error_q;
   assign idle     = idle_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
`timescale 1ns/1ps
module tb_uart_tx_scheduler;

   localparam int NUM_CH   = 3;
   localparam int BUSY_CYC = 100;

   logic                  sys_clk = 1'b0;
   logic                  sys_rst = 1'b1;
   logic [NUM_CH-1:0]     req_valid = '0;
   logic [8*NUM_CH-1:0]   req_data = '0;
   logic                  uart_en;
   logic [7:0]            uart_din;
   logic                  uart_tx_busy = 1'b0;
   logic [1:0]            grant_ch;
   logic [NUM_CH-1:0]     sent;
   logic [NUM_CH-1:0]     overflow;
   logic                  tx_error;
   logic                  idle;

   int errors = 0;
   int checks = 0;
   logic [7:0] exp_bytes[$];
   int         exp_sent[$];
   int         ov_cnt[NUM_CH] = '{default: 0};
   int         txerr_cnt = 0;
   bit         busy_en = 1'b1;
   bit         hold_chk_en = 1'b1;

   uart_tx_scheduler #(
      .NUM_CH       (NUM_CH),
      .TAG_BASE     (8'hA0),
      .HDR_EN       (1),
      .BUSY_TIMEOUT (64)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .uart_en      (uart_en),
      .uart_din     (uart_din),
      .uart_tx_busy (uart_tx_busy),
      .grant_ch     (grant_ch),
      .sent         (sent),
      .overflow     (overflow),
      .tx_error     (tx_error),
      .idle         (idle)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_true(input string tag, input bit cond);
      checks++;
      assert (cond) else begin
         errors++;
         $error("FAIL %s: observed=false expected=true", tag);
      end
   endtask

   // Output monitor: byte scoreboard, sent scoreboard, pulse counters.
   always @(negedge sys_clk) begin
      if (uart_en === 1'b1) begin
         check("en_while_busy", {31'd0, uart_tx_busy}, 32'd0);
         check_true("byte_expected", exp_bytes.size() != 0);
         if (exp_bytes.size() != 0) check("uart_byte", {24'd0, uart_din}, {24'd0, exp_bytes.pop_front()});
      end
      if (sent !== '0) begin
         check_true("sent_expected", exp_sent.size() != 0);
         if (exp_sent.size() != 0) check("sent_vec", {29'd0, sent}, 32'd1 << exp_sent.pop_front());
      end
      for (int c = 0; c < NUM_CH; c++) if (overflow[c] === 1'b1) ov_cnt[c]++;
      if (tx_error === 1'b1) txerr_cnt++;
   end

   // Transmitter model: busy for BUSY_CYC cycles after each uart_en.
   initial begin : busy_model
      logic [7:0] cap;
      forever begin
         @(negedge sys_clk);
         if (uart_en === 1'b1 && busy_en) begin
            cap = uart_din;
            @(posedge sys_clk); #1 uart_tx_busy = 1'b1;
            repeat (BUSY_CYC - 1) @(posedge sys_clk);
            @(negedge sys_clk);
            if (hold_chk_en) check("din_hold", {24'd0, uart_din}, {24'd0, cap});
            @(posedge sys_clk); #1 uart_tx_busy = 1'b0;
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [8*NUM_CH-1:0] put(input logic [8*NUM_CH-1:0] v, input int ch, input logic [7:0] b);
      v[8*ch +: 8] = b;
      return v;
   endfunction

   task automatic strobe(input logic [NUM_CH-1:0] mask, input logic [8*NUM_CH-1:0] data);
      @(posedge sys_clk); #1;
      req_valid = mask;
      req_data  = data;
      @(posedge sys_clk); #1;
      req_valid = '0;
   endtask

   task automatic strobe1(input int ch, input logic [7:0] b);
      strobe(NUM_CH'(1) << ch, put('0, ch, b));
   endtask

   task automatic push_frame(input int ch, input logic [7:0] b);
      exp_bytes.push_back(8'hA0 | 8'(ch));
      exp_bytes.push_back(b);
      exp_sent.push_back(ch);
   endtask

   task automatic wait_done(input string tag, input int budget);
      bit done = 1'b0;
      for (int n = 0; n < budget && !done; n++) begin
         @(negedge sys_clk);
         done = (exp_bytes.size() == 0) && (exp_sent.size() == 0) &&
                (idle === 1'b1) && (uart_tx_busy === 1'b0);
      end
      check_true(tag, done);
   endtask

   task automatic wait_grant(input string tag, input int ch, input int budget);
      bit hit = 1'b0;
      for (int n = 0; n < budget && !hit; n++) begin
         @(negedge sys_clk);
         hit = (idle === 1'b0) && (grant_ch === 2'(ch));
      end
      check_true(tag, hit);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_en"},       {31'd0, uart_en},  32'd0);
      check({tag, "_din"},      {24'd0, uart_din}, 32'd0);
      check({tag, "_grant"},    {30'd0, grant_ch}, 32'd0);
      check({tag, "_sent"},     {29'd0, sent},     32'd0);
      check({tag, "_overflow"}, {29'd0, overflow}, 32'd0);
      check({tag, "_txerr"},    {31'd0, tx_error}, 32'd0);
      check({tag, "_idle"},     {31'd0, idle},     32'd1);
   endtask

   initial begin : stim
      int ov1_base;
      int k;
      bit seen;

      // Reset values
      @(negedge sys_clk);
      check_reset_outputs("rst");
      repeat (2) @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      repeat (3) @(posedge sys_clk);

      // Single request with latency check: strobe launched after edge k,
      // uart_en must be high after edge k+2 and not after edge k+1.
      push_frame(1, 8'h23);
      @(posedge sys_clk); #1;
      req_valid = 3'b010;
      req_data  = put('0, 1, 8'h23);
      @(posedge sys_clk); #1;
      req_valid = '0;
      @(negedge sys_clk);
      check("lat_early", {31'd0, uart_en}, 32'd0);
      @(negedge sys_clk);
      check("lat_en", {31'd0, uart_en}, 32'd1);
      wait_done("single_done", 800);
      check("single_idle", {31'd0, idle}, 32'd1);

      // Priority: ch0 and ch2 together -> ch0 first
      push_frame(0, 8'h5A);
      push_frame(2, 8'hC2);
      strobe(3'b101, put(put('0, 0, 8'h5A), 2, 8'hC2));
      wait_done("prio_done", 1200);
      repeat (20) @(negedge sys_clk);
      check("prio_quiet_idle", {31'd0, idle}, 32'd1);

      // Round-robin: pointer wrapped to 1 after ch2
      ov1_base = ov_cnt[1];
      push_frame(1, 8'h31);
      push_frame(2, 8'h32);
      push_frame(1, 8'h12);
      push_frame(2, 8'h22);
      strobe(3'b110, put(put('0, 1, 8'h31), 2, 8'h32));
      wait_grant("rr_g1", 1, 20);
      repeat (5) @(posedge sys_clk);
      strobe1(1, 8'h12);
      wait_grant("rr_g2", 2, 800);
      repeat (5) @(posedge sys_clk);
      strobe1(2, 8'h22);
      wait_done("rr_done", 2400);
      check("rr_no_ovf", ov_cnt[1] - ov1_base, 32'd0);

      // Overflow while ch0 frame is in flight: last data wins
      ov1_base = ov_cnt[1];
      push_frame(0, 8'h40);
      push_frame(1, 8'h11);
      strobe1(0, 8'h40);
      wait_grant("ovf_g0", 0, 20);
      repeat (5) @(posedge sys_clk);
      strobe1(1, 8'h10);
      strobe1(1, 8'h11);
      wait_done("ovf_done", 1200);
      check("ovf_count", ov_cnt[1] - ov1_base, 32'd1);
      check("ovf_other", ov_cnt[0] + ov_cnt[2], 32'd0);

      // Set wins: ch1 strobed again exactly on its grant edge
      ov1_base = ov_cnt[1];
      push_frame(1, 8'h55);
      push_frame(1, 8'h66);
      @(posedge sys_clk); #1;
      req_valid = 3'b010;
      req_data  = put('0, 1, 8'h55);
      @(posedge sys_clk); #1;
      req_data  = put('0, 1, 8'h66);
      @(posedge sys_clk); #1;
      req_valid = '0;
      wait_done("setwin_done", 1200);
      check("setwin_no_ovf", ov_cnt[1] - ov1_base, 32'd0);

      // Timeout: ch2 (pointer now 2) gets no busy, then ch1 is served
      busy_en = 1'b0;
      exp_bytes.push_back(8'hA2);
      push_frame(1, 8'h78);
      strobe(3'b110, put(put('0, 1, 8'h78), 2, 8'h77));
      seen = 1'b0;
      for (int n = 0; n < 10 && !seen; n++) begin
         @(negedge sys_clk);
         seen = (uart_en === 1'b1);
      end
      check_true("to_first_en", seen);
      k = 0;
      seen = 1'b0;
      while (!seen && k < 200) begin
         @(negedge sys_clk);
         k++;
         seen = (tx_error === 1'b1);
      end
      busy_en = 1'b1;
      check_true("to_fired", seen);
      check_true("to_latency", k >= 64 && k <= 66);
      check("to_idle", {31'd0, idle}, 32'd1);
      wait_done("to_next_served", 1200);
      check("to_count", txerr_cnt, 32'd1);

      // Reset during DAT_WLO of a ch0 frame, ch1 pending
      exp_bytes.push_back(8'hA0);
      exp_bytes.push_back(8'h98);
      strobe(3'b011, put(put('0, 0, 8'h98), 1, 8'h99));
      seen = 1'b0;
      for (int n = 0; n < 600 && !seen; n++) begin
         @(negedge sys_clk);
         seen = (exp_bytes.size() == 0);
      end
      check_true("rstmid_data_sent", seen);
      repeat (10) @(negedge sys_clk);
      hold_chk_en = 1'b0;
      @(posedge sys_clk); #1 sys_rst = 1'b1;
      @(negedge sys_clk);
      check_reset_outputs("rstmid");
      @(posedge sys_clk); #1 sys_rst = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 300 && !seen; n++) begin
         @(negedge sys_clk);
         seen = (uart_tx_busy === 1'b0);
      end
      check_true("rstmid_busy_drop", seen);
      repeat (30) @(negedge sys_clk);
      check("rstmid_pend_clear_idle", {31'd0, idle}, 32'd1);
      hold_chk_en = 1'b1;
      push_frame(2, 8'h5C);
      strobe1(2, 8'h5C);
      wait_done("rstmid_after", 800);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
